// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a standard or first-word-fall-through read port.
//
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_wr_en, i_data_wr                  -> write side
//   o_full, o_almost_full               -> write-side status
//   i_rd_en                             -> read request (pop acknowledge in FWFT mode)
//   o_data_rd, o_valid_rd               -> read data
//   o_empty, o_almost_empty, o_count    -> read-side status / occupancy
//   o_overflow, o_underflow, i_clr_err  -> sticky error flags and their clear
module fifo_sync_flags #(
  parameter int SIZE_DATA       = 8,
  parameter int SIZE_DEPTH      = 16,
  parameter int SIZE_ADDR       = $clog2(SIZE_DEPTH),
  parameter int ALMOST_FULL_TH  = SIZE_DEPTH - 4,
  parameter int ALMOST_EMPTY_TH = 4,
  parameter bit FWFT            = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [SIZE_DATA-1:0] i_data_wr,
  output logic                 o_full,
  output logic                 o_almost_full,
  input  logic                 i_rd_en,
  output logic [SIZE_DATA-1:0] o_data_rd,
  output logic                 o_valid_rd,
  output logic                 o_empty,
  output logic                 o_almost_empty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow,
  input  logic                 i_clr_err
);

  localparam logic [SIZE_ADDR:0] L_DEPTH = (SIZE_ADDR+1)'(SIZE_DEPTH);
  localparam logic [SIZE_ADDR:0] L_AF    = (SIZE_ADDR+1)'(ALMOST_FULL_TH);
  localparam logic [SIZE_ADDR:0] L_AE    = (SIZE_ADDR+1)'(ALMOST_EMPTY_TH);

  logic [SIZE_DATA-1:0] r_mem [SIZE_DEPTH];
  logic [SIZE_ADDR-1:0] r_wr_ptr;
  logic [SIZE_ADDR-1:0] r_rd_ptr;
  logic [SIZE_ADDR:0]   r_count;
  logic                 r_ovf;
  logic                 r_unf;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  // Status flags derive from the registered count only; nothing is bypassed.
  assign w_full  = (r_count == L_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = i_wr_en & ~w_full;
  assign w_rd_ok = i_rd_en & ~w_empty;

  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= L_AF);
  assign o_almost_empty = (r_count <= L_AE);
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_unf;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_data_wr;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (i_wr_en & w_full)  | (r_ovf & ~i_clr_err);
      r_unf <= (i_rd_en & w_empty) | (r_unf & ~i_clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented combinationally from memory while non-empty.
      assign o_data_rd  = w_empty ? '0 : r_mem[r_rd_ptr];
      assign o_valid_rd = ~w_empty;
    end else begin : g_std
      logic [SIZE_DATA-1:0] r_data_rd;
      logic                 r_valid_rd;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_data_rd  <= '0;
          r_valid_rd <= 1'b0;
        end else begin
          r_valid_rd <= w_rd_ok;
          if (w_rd_ok) r_data_rd <= r_mem[r_rd_ptr];
        end
      end

      assign o_data_rd  = r_data_rd;
      assign o_valid_rd = r_valid_rd;
    end
  endgenerate

endmodule
